// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam int unsigned FETCH_INSTR_W = 32;
  localparam int unsigned FETCH_PC_W    = 32;

  // addi x0,x0,0: decodes with regWrite=0, so bubbles need no gating in ID
  localparam logic [FETCH_INSTR_W-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_S_RESET   = 2'd0,
    FETCH_S_FETCH   = 2'd1,
    FETCH_S_WAIT_ID = 2'd2,
    FETCH_S_KILL    = 2'd3
  } fetch_state_e;

  function automatic logic [FETCH_PC_W-1:0] fetch_align(input logic [FETCH_PC_W-1:0] a);
    return a & ~FETCH_PC_W'(3);
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch with IF/ID register and one-entry skid buffer.
// One outstanding imem request; redirects squash all wrong-path work.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [FETCH_PC_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned           INSTR_SIZE = FETCH_INSTR_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic                  i_redirect_valid,
  input  logic [FETCH_PC_W-1:0] i_redirect_pc,
  output logic                  o_imem_req,
  output logic [FETCH_PC_W-1:0] o_imem_addr,
  input  logic                  i_imem_rvalid,
  input  logic [INSTR_SIZE-1:0] i_imem_rdata,
  output logic                  o_id_valid,
  output logic [INSTR_SIZE-1:0] o_id_instr,
  output logic [FETCH_PC_W-1:0] o_id_pc
);

  localparam logic [INSTR_SIZE-1:0] NOP = INSTR_SIZE'(INSTR_NOP);

  fetch_state_e            r_state;
  logic [FETCH_PC_W-1:0]   r_fetch_pc;
  logic [FETCH_PC_W-1:0]   r_redir_pc;
  logic [INSTR_SIZE-1:0]   r_buf_instr;
  logic                    r_req;
  logic                    r_id_valid;
  logic [INSTR_SIZE-1:0]   r_id_instr;
  logic [FETCH_PC_W-1:0]   r_id_pc;

  logic [FETCH_PC_W-1:0]   w_redir_pc;
  logic [FETCH_PC_W-1:0]   w_pc_inc;
  logic                    w_load;
  logic [INSTR_SIZE-1:0]   w_instr;
  logic [FETCH_PC_W-1:0]   w_pc;

  assign w_redir_pc = fetch_align(i_redirect_pc);
  assign w_pc_inc   = r_fetch_pc + FETCH_PC_W'(4);

  // Candidate IF/ID payload; the skid entry's pc is still fetch_pc in S_WAIT_ID
  always_comb begin
    w_load  = 1'b0;
    w_instr = NOP;
    w_pc    = '0;
    if (r_state == FETCH_S_FETCH && i_imem_rvalid) begin
      w_load  = 1'b1;
      w_instr = i_imem_rdata;
      w_pc    = r_fetch_pc;
    end else if (r_state == FETCH_S_WAIT_ID) begin
      w_load  = 1'b1;
      w_instr = r_buf_instr;
      w_pc    = r_fetch_pc;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= FETCH_S_RESET;
      r_fetch_pc  <= RESET_PC;
      r_redir_pc  <= '0;
      r_buf_instr <= NOP;
      r_req       <= 1'b0;
    end else begin
      case (r_state)
        FETCH_S_RESET: begin
          r_state <= FETCH_S_FETCH;
          r_req   <= 1'b1;
        end
        FETCH_S_FETCH: begin
          if (i_redirect_valid) begin
            if (i_imem_rvalid) begin
              r_fetch_pc <= w_redir_pc;
            end else begin
              r_redir_pc <= w_redir_pc;
              r_state    <= FETCH_S_KILL;
            end
          end else if (i_imem_rvalid) begin
            if (!i_stall && !i_flush) begin
              r_fetch_pc <= w_pc_inc;
            end else begin
              r_buf_instr <= i_imem_rdata;
              r_state     <= FETCH_S_WAIT_ID;
              r_req       <= 1'b0;
            end
          end
        end
        FETCH_S_WAIT_ID: begin
          if (i_redirect_valid) begin
            r_fetch_pc <= w_redir_pc;
            r_state    <= FETCH_S_FETCH;
            r_req      <= 1'b1;
          end else if (!i_stall && !i_flush) begin
            r_fetch_pc <= w_pc_inc;
            r_state    <= FETCH_S_FETCH;
            r_req      <= 1'b1;
          end
        end
        FETCH_S_KILL: begin
          // Wait out the in-flight response, then jump to the latest target
          if (i_imem_rvalid) begin
            r_fetch_pc <= i_redirect_valid ? w_redir_pc : r_redir_pc;
            r_state    <= FETCH_S_FETCH;
          end else if (i_redirect_valid) begin
            r_redir_pc <= w_redir_pc;
          end
        end
        default: begin
          r_state <= FETCH_S_RESET;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  // IF/ID register: redirect/flush bubble, stall holds, else load or bubble
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_id_valid <= 1'b0;
      r_id_instr <= NOP;
      r_id_pc    <= '0;
    end else if (i_redirect_valid || i_flush) begin
      r_id_valid <= 1'b0;
      r_id_instr <= NOP;
      r_id_pc    <= '0;
    end else if (!i_stall) begin
      r_id_valid <= w_load;
      r_id_instr <= w_instr;
      r_id_pc    <= w_pc;
    end
  end

  assign o_imem_req  = r_req;
  assign o_imem_addr = r_fetch_pc;
  assign o_id_valid  = r_id_valid;
  assign o_id_instr  = r_id_instr;
  assign o_id_pc     = r_id_pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic checked
// against a program-order model of the instruction stream.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        rvalid;
  logic [31:0] rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  fetch_stage #(.RESET_PC(RST_PC), .INSTR_SIZE(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_flush(flush),
    .i_redirect_valid(redirect), .i_redirect_pc(redirect_pc),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
    .o_id_valid(id_valid), .o_id_instr(id_instr), .o_id_pc(id_pc)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'hC0DE_0000) + 32'h0000_0100;
  endfunction

  // Memory model: per-request latency, response on cycle index == lat
  bit tie_rvalid = 1'b0;
  bit rand_lat   = 1'b0;
  int fixed_lat  = 0;
  int lat        = 0;
  int cnt        = 0;
  logic prev_req = 1'b0, prev_hs = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (!prev_req || prev_hs) begin
      cnt = 0;
      lat = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
    end else begin
      cnt++;
    end
    rvalid   = tie_rvalid ? 1'b1 : (imem_req && cnt >= lat);
    rdata    = mem_word(imem_addr);
    prev_req = imem_req;
    prev_hs  = imem_req && rvalid;
  endtask

  task automatic wait_addr(input logic [31:0] a);
    int i = 0;
    while (!(imem_req && imem_addr == a) && i < 64) begin
      tick();
      i++;
    end
    chk("reach_addr", 64'({imem_req, imem_addr}), 64'({1'b1, a}));
  endtask

  // Reference model: expected next program-order pc and pending squash state
  logic [31:0] exp_pc = RST_PC;
  logic [31:0] kill_tgt = '0;
  bit          kill = 1'b0;
  int          ndeliv = 0;
  bit          p_rst = 1'b1, p_kill = 1'b0;
  logic        p_stall, p_flush, p_redir, p_req, p_rvalid, p_v;
  logic [31:0] p_tgt, p_addr, p_instr, p_pc;

  always @(negedge clk) begin
    bit cur_kill;
    if (rst) begin
      exp_pc = RST_PC;
      kill   = 1'b0;
      p_rst  = 1'b1;
    end else begin
      if (p_rst) begin
        chk("rst_bubble", 64'(id_valid), 64'(0));
      end else begin
        if (p_redir || p_flush) begin
          chk("squash_bubble", 64'(id_valid), 64'(0));
        end else if (p_stall) begin
          chk("hold_pc", 64'({id_valid, id_pc}), 64'({p_v, p_pc}));
          chk("hold_instr", 64'(id_instr), 64'(p_instr));
        end else if (id_valid) begin
          chk("order_pc", 64'(id_pc), 64'(exp_pc));
          chk("order_instr", 64'(id_instr), 64'(mem_word(id_pc)));
          exp_pc = exp_pc + 32'd4;
          ndeliv++;
        end
        if (p_req && !p_rvalid)
          chk("addr_stable", 64'({imem_req, imem_addr}), 64'({1'b1, p_addr}));
        if (p_req && p_rvalid && !p_kill && !p_stall && !p_flush && !p_redir)
          chk("deliver_latency", 64'({id_valid, id_pc}), 64'({1'b1, p_addr}));
        if (p_redir && (!p_req || p_rvalid))
          chk("redirect_fetch", 64'({imem_req, imem_addr}), 64'({1'b1, p_tgt}));
        if (p_kill && p_req && p_rvalid && !p_redir)
          chk("kill_resolve", 64'({imem_req, imem_addr}), 64'({1'b1, kill_tgt}));
      end
      if (!id_valid)
        chk("bubble_form", 64'({id_instr, id_pc}), {NOP, 32'h0});
      cur_kill = kill;
      if (redirect) begin
        exp_pc   = redirect_pc & ~32'h3;
        kill_tgt = redirect_pc & ~32'h3;
        kill     = imem_req && !rvalid;
      end else if (kill && rvalid) begin
        kill = 1'b0;
      end
      p_kill   = cur_kill;
      p_stall  = stall;
      p_flush  = flush;
      p_redir  = redirect;
      p_tgt    = redirect_pc & ~32'h3;
      p_req    = imem_req;
      p_rvalid = rvalid;
      p_addr   = imem_addr;
      p_v      = id_valid;
      p_instr  = id_instr;
      p_pc     = id_pc;
      p_rst    = 1'b0;
    end
  end

  initial begin
    int since;
    int pulses;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = '0;
    rvalid = 1'b0; rdata = '0;
    tie_rvalid = 1'b1;
    repeat (3) tick();
    chk("reset_req", 64'(imem_req), 64'(0));
    chk("reset_addr", 64'(imem_addr), 64'(RST_PC));
    chk("reset_id", 64'({id_valid, id_pc}), 64'(0));
    chk("reset_instr", 64'(id_instr), 64'(NOP));

    // Zero-wait memory straight out of reset
    rst = 1'b0;
    tick();
    chk("zw_first_req", 64'({imem_req, imem_addr, id_valid}), 64'({1'b1, RST_PC, 1'b0}));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("zw_stream", 64'({id_valid, id_pc}), 64'({1'b1, RST_PC + 32'(4 * i)}));
    end

    // Two-cycle stall while 0x10 is returned
    wait_addr(32'h10);
    stall = 1'b1;
    tick();
    chk("stall_hold0", 64'({id_valid, id_pc, imem_req}), 64'({1'b1, 32'h0C, 1'b0}));
    tick();
    chk("stall_hold1", 64'({id_valid, id_pc, imem_req}), 64'({1'b1, 32'h0C, 1'b0}));
    stall = 1'b0;
    tick();
    chk("stall_rel0", 64'({id_valid, id_pc}), 64'({1'b1, 32'h10}));
    tick();
    chk("stall_rel1", 64'({id_valid, id_pc}), 64'({1'b1, 32'h14}));

    // Flush alone with a response at 0x30
    wait_addr(32'h30);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_bubble", 64'(id_valid), 64'(0));
    tick();
    chk("flush_next", 64'({id_valid, id_pc}), 64'({1'b1, 32'h30}));
    tick();
    chk("flush_after", 64'({id_valid, id_pc}), 64'({1'b1, 32'h34}));

    // PC wrap and unaligned redirect target
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    chk("wrap_fetch", 64'({imem_req, imem_addr, id_valid}), 64'({1'b1, 32'hFFFF_FFFC, 1'b0}));
    tick();
    chk("wrap_top", 64'({id_valid, id_pc, imem_addr}), 64'({1'b1, 32'hFFFF_FFFC, 32'h0}));
    tick();
    chk("wrap_zero", 64'({id_valid, id_pc}), 64'({1'b1, 32'h0}));
    redirect = 1'b1; redirect_pc = 32'h203;
    tick();
    redirect = 1'b0;
    chk("unaligned_fetch", 64'(imem_addr), 64'(32'h200));
    tick();
    chk("unaligned_id", 64'({id_valid, id_pc}), 64'({1'b1, 32'h200}));

    // Three-cycle memory: throughput then redirect during an in-flight fetch
    rst = 1'b1; tie_rvalid = 1'b0; fixed_lat = 2;
    repeat (2) tick();
    rst = 1'b0;
    repeat (8) tick();
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (id_valid) pulses++;
    end
    chk("lat3_rate", 64'(pulses), 64'(3));
    wait_addr(32'h20);
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    chk("kill_enter", 64'({imem_req, imem_addr, id_valid}), 64'({1'b1, 32'h20, 1'b0}));
    tick();
    chk("kill_wait", 64'({imem_addr, id_valid}), 64'({32'h20, 1'b0}));
    tick();
    chk("kill_target", 64'({imem_addr, id_valid}), 64'({32'h100, 1'b0}));
    for (int i = 0; i < 8 && !id_valid; i++) tick();
    chk("kill_first", 64'({id_valid, id_pc}), 64'({1'b1, 32'h100}));

    // Randomized traffic with one reset in the middle of a request
    rst = 1'b1; rand_lat = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    since = 0;
    ndeliv = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      since++;
      if (c == 1500) rst = 1'b1;
      if (c == 1503) begin
        rst = 1'b0;
        since = 0;
      end
      stall    = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 11) == 0);
      redirect = !rst && since > 3 && ($urandom_range(0, 13) == 0);
      case ($urandom_range(0, 3))
        0:       redirect_pc = 32'hFFFF_FFFC;
        1:       redirect_pc = $urandom;
        2:       redirect_pc = $urandom & 32'h0000_0FFF;
        default: redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
      endcase
    end
    stall = 1'b0; flush = 1'b0; redirect = 1'b0;
    repeat (4) tick();
    chk("random_progress", 64'(ndeliv > 300), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register; sits directly upstream of the ID-stage control unit and immediate generator.
- Owns the PC, issues requests to instruction memory, and absorbs ID stalls with a one-entry skid buffer.
- Takes branch/jump redirects from EX and presents {valid, instr, pc} to ID.
- Bubbles are the canonical NOP (addi x0,x0,0), so downstream decode sees regWrite=0 with no extra gating.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- INSTR_SIZE, 32, instruction width (matches `INSTR_SIZE).

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  ID cannot accept; hold IF/ID register
- flush  in  1  force IF/ID to bubble this cycle
- redirect_valid  in  1  EX resolved taken branch/jump
- redirect_pc  in  32  target address; bits[1:0] ignored (treated as 0)
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address; stable while imem_req=1
- imem_rvalid  in  1  response valid for this cycle's imem_addr
- imem_rdata  in  INSTR_SIZE  fetched instruction
- id_valid  out  1  IF/ID holds a real instruction
- id_instr  out  INSTR_SIZE  instruction to ID (NOP when invalid)
- id_pc  out  32  PC of id_instr

Behaviour:
- Memory handshake:
  - imem_rvalid may rise in the same cycle imem_req is raised (zero-wait memory) or any later cycle.
  - Only one request is outstanding at a time.
  - imem_addr must not change while imem_req=1 until imem_rvalid is seen.
- Reset (async): state=S_RESET, fetch_pc=RESET_PC, imem_req=0, id_valid=0, id_instr=NOP, id_pc=0, skid buffer empty.
- Priority each cycle: redirect_valid > flush > stall.
- IF/ID register:
  - Loads a bubble {0, NOP, 0} on redirect or flush.
  - Holds its value while stall=1.
  - Otherwise loads the delivered instruction if there is one, else a bubble.
- S_RESET: imem_req=0. Go to S_FETCH next cycle.
- S_FETCH: imem_req=1, imem_addr=fetch_pc.
  - redirect with rvalid: discard data; fetch_pc<=redirect_pc; stay in S_FETCH.
  - redirect without rvalid: redir_pc<=redirect_pc; go to S_KILL.
  - rvalid, no stall, no flush: IF/ID<={1, rdata, fetch_pc}; fetch_pc+=4; stay.
  - rvalid with stall or flush: buf<={rdata, fetch_pc}; go to S_WAIT_ID; fetch_pc unchanged.
  - No rvalid: stay.
- S_WAIT_ID: imem_req=0.
  - redirect: drop buf; fetch_pc<=redirect_pc; go to S_FETCH.
  - No stall, no flush: IF/ID<={1, buf}; fetch_pc+=4; go to S_FETCH.
  - Otherwise: hold.
- S_KILL: imem_req=1, imem_addr=old fetch_pc.
  - A further redirect overwrites redir_pc (latest wins).
  - On rvalid: discard data; fetch_pc<=redir_pc (or the same-cycle redirect_pc if one arrives); go to S_FETCH.
  - IF/ID is bubble or held throughout.
- Throughput and latency:
  - 1 instruction/cycle with zero-wait memory.
  - An instruction appears on id_* the cycle after its rvalid.
  - Redirect-to-first-target-fetch: next cycle in S_FETCH/S_WAIT_ID; after the in-flight response in S_KILL.
- Arithmetic: fetch_pc+4 is modulo 2^32 (0xFFFF_FFFC wraps to 0).
- A redirect never leaves a wrong-path instruction in IF/ID or the skid buffer.
- Reset mid-request: the request is abandoned. The memory must tolerate imem_req dropping; any later rvalid while in S_RESET is ignored.

Decomposition:
- Shared defines file gets:
  - `INSTR_NOP (32'h0000_0013).
  - State encodings FETCH_S_RESET/S_FETCH/S_WAIT_ID/S_KILL (2 bits).
  - Existing `INSTR_SIZE.
- Single module. The skid buffer and IF/ID register are small enough to stay inline; no sub-module.

Test Plan:
- Zero-wait memory, rvalid tied 1, rdata=addr-derived, from reset → pcs 0x0,0x4,0x8 appear on id_pc in consecutive cycles starting 2 cycles after rst falls; id_valid=1.
- Memory with 3-cycle latency → imem_addr stable 3 cycles per fetch; id_valid pulses once per 3 cycles; id_pc increments by 4.
- stall=1 for 2 cycles while rvalid=1 at pc 0x10 → IF/ID holds 0x0C; 0x10 is buffered with imem_req=0; after release id_pc=0x10 then 0x14; no instruction lost or duplicated.
- redirect_valid with redirect_pc=0x100 while a 3-cycle fetch of 0x20 is in flight → S_KILL; 0x20 data discarded; next imem_addr=0x100; id_valid=0 until 0x100 is delivered.
- flush=1 alone with rvalid at 0x30 → id_valid=0 that cycle; next cycle id_pc=0x30, id_valid=1.
- redirect_pc=0xFFFF_FFFC → fetch 0xFFFF_FFFC then 0x0; redirect_pc=0x203 → imem_addr=0x200.
